// File: rtl/apb_st_pkg.sv
// Shared types and width helpers for the APB4 memory-backed completer.
package apb_st_pkg;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

  function automatic int offset_bits(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/apb_st_regfile.sv
// Byte-writable word store: synchronous clear, byte-enable write, combinational read.
module apb_st_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);
  localparam int SW = DATA_WIDTH / 8;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem <= '0;
    end else if (we) begin
      for (int b = 0; b < SW; b++)
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // Non-power-of-two depths leave index codes with no backing word.
  assign rdata = ({1'b0, raddr} < (IDX_W+1)'(DEPTH)) ? mem[raddr] : '0;
endmodule

// File: rtl/apb_st_slv_mem.sv
// APB4 completer over a byte-writable memory with programmable wait states,
// pslverr on bad accesses and a pulse on requester protocol violations.
module apb_st_slv_mem
  import apb_st_pkg::*;
#(
  parameter int                  ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                  DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [3:0]              wait_cycles,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic                    proto_err
);
  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int OB    = offset_bits(DATA_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                  write;
    logic                  err;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BPW-1:0]        strb;
    logic [DATA_WIDTH-1:0] rdata;
  } req_t;

  state_t                state;
  logic [3:0]            cnt;
  req_t                  req_q, req_d, resp_src;
  logic [ADDR_WIDTH:0]   diff;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  setup, access, mem_we;

  assign setup  = psel & ~penable;
  assign access = psel & penable;

  // One extra bit so an address below the base shows up as a borrow, not a wrap.
  assign diff     = {1'b0, paddr} - {1'b0, BASE_ADDR};
  assign word_idx = diff[ADDR_WIDTH-1:0] >> OB;

  always_comb begin
    req_d       = '0;
    req_d.write = pwrite;
    req_d.idx   = word_idx[IDX_W-1:0];
    req_d.wdata = pwdata;
    req_d.strb  = pstrb;
    req_d.rdata = rd_data;
    req_d.err   = diff[ADDR_WIDTH]
                | (word_idx >= ADDR_WIDTH'(DEPTH))
                | (|(paddr & ADDR_WIDTH'(BPW - 1)))
                | (~pwrite & (|pstrb));
    resp_src    = (state == IDLE) ? req_d : req_q;
  end

  assign mem_we = (state == RESP) & access & req_q.write & ~req_q.err;

  apb_st_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (mem_we),
    .waddr  (req_q.idx),
    .wdata  (req_q.wdata),
    .wstrb  (req_q.strb),
    .raddr  (word_idx[IDX_W-1:0]),
    .rdata  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
      case (state)
        IDLE: begin
          if (setup) begin
            req_q <= req_d;
            if (wait_cycles == 4'd0) begin
              state   <= RESP;
              pready  <= 1'b1;
              pslverr <= resp_src.err;
              prdata  <= (~resp_src.write & ~resp_src.err) ? resp_src.rdata : '0;
            end else begin
              cnt   <= wait_cycles;
              state <= WAIT;
            end
          end else if (access) begin
            proto_err <= 1'b1;
          end
        end
        WAIT: begin
          if (!access) begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state   <= RESP;
              pready  <= 1'b1;
              pslverr <= resp_src.err;
              prdata  <= (~resp_src.write & ~resp_src.err) ? resp_src.rdata : '0;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          if (!access) proto_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_st_slv_mem.sv
// Directed bench for apb_st_slv_mem: vector table plus hand-written corner sequences.
module tb_apb_st_slv_mem;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb, wait_cycles;
  logic [31:0] prdata;
  logic        pready, pslverr, proto_err;

  int checks = 0;
  int errors = 0;
  int proto_cnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (proto_err) proto_cnt++;

  apb_st_slv_mem dut (
    .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .wait_cycles(wait_cycles),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .proto_err(proto_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered just after a rising edge; leaves just after the edge that ends RESP.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [3:0] wc,
                      output logic [31:0] rd, output logic er, output int cyc);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    wait_cycles = wc;
    cyc = 1;
    @(posedge clk); #1;
    penable = 1'b1;
    // Scramble everything: only the setup-phase values may matter.
    pwrite = ~w; paddr = ~a; pwdata = ~d; pstrb = ~s; wait_cycles = ~wc;
    cyc = 2;
    rd = 32'hFFFF_FFFF; er = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pready) break;
      @(posedge clk); #1;
      cyc++;
    end
    if (pready) begin
      rd = prdata; er = pslverr;
    end else begin
      cyc = -1;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [3:0]  wc;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t        vt[13];
  logic [31:0] rd;
  logic        er;
  int          cyc;

  initial begin
    vt[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 4'd0, 32'h0,        1'b0, 2};
    vt[1]  = '{1'b0, 32'h08, 32'h0,        4'h0, 4'd0, 32'hDEADBEEF, 1'b0, 2};
    vt[2]  = '{1'b0, 32'h04, 32'h0,        4'h0, 4'd3, 32'h0,        1'b0, 5};
    vt[3]  = '{1'b1, 32'h00, 32'h11223344, 4'hF, 4'd0, 32'h0,        1'b0, 2};
    vt[4]  = '{1'b1, 32'h00, 32'h0000AB00, 4'h2, 4'd1, 32'h0,        1'b0, 3};
    vt[5]  = '{1'b0, 32'h00, 32'h0,        4'h0, 4'd0, 32'h1122AB44, 1'b0, 2};
    vt[6]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 4'd0, 32'h0,        1'b1, 2};
    vt[7]  = '{1'b1, 32'h06, 32'h87654321, 4'hF, 4'd0, 32'h0,        1'b1, 2};
    vt[8]  = '{1'b1, 32'h3C, 32'hA5A5A5A5, 4'hF, 4'd2, 32'h0,        1'b0, 4};
    vt[9]  = '{1'b0, 32'h3C, 32'h0,        4'h0, 4'd0, 32'hA5A5A5A5, 1'b0, 2};
    vt[10] = '{1'b0, 32'h08, 32'h0,        4'h1, 4'd0, 32'h0,        1'b1, 2};
    vt[11] = '{1'b0, 32'h40, 32'h0,        4'h0, 4'd0, 32'h0,        1'b1, 2};
    vt[12] = '{1'b0, 32'h00, 32'h0,        4'h0, 4'd0, 32'h1122AB44, 1'b0, 2};

    reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; wait_cycles = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", {31'h0, pready}, 32'h0);
    chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("rst_proto_err", {31'h0, proto_err}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      xfer(vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].wc, rd, er, cyc);
      chk($sformatf("v%0d_prdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d_pslverr", i), {31'h0, er}, {31'h0, vt[i].exp_err});
      chk($sformatf("v%0d_cycles", i), cyc, vt[i].exp_cyc);
    end
    chk("table_no_proto_err", proto_cnt, 32'd0);

    // psel dropped in WAIT: abort with a single proto_err pulse and no write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
    pwdata = 32'hCAFEF00D; pstrb = 4'hF; wait_cycles = 4'd2;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("drop_pre_proto", {31'h0, proto_err}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_proto_pulse", {31'h0, proto_err}, 32'h1);
    chk("drop_pready", {31'h0, pready}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_proto_clear", {31'h0, proto_err}, 32'h0);
    @(posedge clk); #1;
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, er, cyc);
    chk("drop_no_write", rd, 32'h0);
    chk("drop_next_ok_err", {31'h0, er}, 32'h0);
    chk("drop_next_ok_cyc", cyc, 32'd2);

    // Access phase with no setup from IDLE: pulse, ignored.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h08; pstrb = 4'h0;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("idle_access_proto", {31'h0, proto_err}, 32'h1);
    chk("idle_access_pready", {31'h0, pready}, 32'h0);
    @(posedge clk); #1;
    chk("proto_pulse_count", proto_cnt, 32'd2);

    // Reset during WAIT of a write to 0xC after 0xC already holds data.
    xfer(1'b1, 32'h0C, 32'h55AA55AA, 4'hF, 4'd0, rd, er, cyc);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
    pwdata = 32'h12345678; pstrb = 4'hF; wait_cycles = 4'd3;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_pready", {31'h0, pready}, 32'h0);
    chk("mid_rst_prdata", prdata, 32'h0);
    chk("mid_rst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("mid_rst_proto", {31'h0, proto_err}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1; psel = 1'b0; penable = 1'b0;
    xfer(1'b0, 32'h0C, 32'h0, 4'h0, 4'd0, rd, er, cyc);
    chk("post_rst_0c", rd, 32'h0);
    chk("post_rst_0c_err", {31'h0, er}, 32'h0);
    xfer(1'b0, 32'h08, 32'h0, 4'h0, 4'd0, rd, er, cyc);
    chk("post_rst_08_cleared", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
